// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the MMIO UART block: register offsets inside the
// MMIO window, FSM state encodings and a small sizing helper.
package uart_mmio_pkg;

    // Register offsets (addr[7:0]) inside the MMIO window
    localparam logic [7:0] UART_CTRL = 8'h00;   // R  status {overrun, rx_valid, tx_ready}
    localparam logic [7:0] UART_RX   = 8'h04;   // R  received byte, pops on read
    localparam logic [7:0] UART_TX   = 8'h08;   // W  byte to transmit
    localparam logic [7:0] CYC_CNT   = 8'h10;   // R  free-running cycle counter
    localparam logic [7:0] INST_CNT  = 8'h14;   // R  retired instruction counter
    localparam logic [7:0] CNT_RST   = 8'h18;   // W  any store clears both counters

    // Depth of the optional receive FIFO (must be a power of two)
    localparam int RX_FIFO_DEPTH = 8;

    typedef enum logic {
        TX_IDLE  = 1'b0,
        TX_SHIFT = 1'b1
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Bits needed for a counter that runs 0 .. n-1
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, start-bit qualification at
// half a bit, eight data samples at bit centres and a stop-bit check.
// A good frame produces a one-cycle rx_strobe with the byte on rx_data;
// a frame with a low stop bit is silently discarded.
module uart_rx
    import uart_mmio_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_rx,
    output logic [7:0] rx_data,
    output logic       rx_strobe
);

    localparam int BIT_CYC  = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CW       = cnt_width(BIT_CYC);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);

    logic            sync1_reg, sync2_reg, prev_reg;
    rx_state_t       state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [2:0]      bit_reg, bit_next;
    logic [7:0]      shift_reg, shift_next;
    logic            strobe_reg, strobe_next;

    // Synchronise the line and keep one extra stage for falling-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
        end else begin
            sync1_reg <= serial_rx;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    // Receiver state, bit timer, shift register and commit strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= RX_IDLE;
            cnt_reg    <= '0;
            bit_reg    <= '0;
            shift_reg  <= '0;
            strobe_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            strobe_reg <= strobe_next;
        end
    end

    // Next-state logic: sample mid-start, mid-data bits and mid-stop
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        bit_next    = bit_reg;
        shift_next  = shift_reg;
        strobe_next = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                if (prev_reg && !sync2_reg) begin
                    state_next = RX_START;
                    cnt_next   = '0;
                end
            end
            RX_START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next   = '0;
                    bit_next   = '0;
                    // Line back high at mid-start is a glitch, not a frame
                    state_next = sync2_reg ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {sync2_reg, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
                        state_next = RX_STOP;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next    = '0;
                    strobe_next = sync2_reg;
                    state_next  = RX_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign rx_data   = shift_reg;
    assign rx_strobe = strobe_reg;

endmodule

// File: rtl/uart_mmio.sv
// MMIO slave for the memory stage: address decode with same-cycle read data,
// 8N1 UART transmitter, receive buffering and the cycle / retired-instruction
// performance counters.
// Build option: define UART_RX_FIFO_EN to replace the single-byte receive
// holding register with an 8-entry receive FIFO.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int         CLOCK_FREQ = 50_000_000,
    parameter int         BAUD_RATE  = 115200,
    parameter logic [3:0] MMIO_NIB   = 4'h8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  we,
    input  logic        re,
    input  logic        inst_retire,
    input  logic        serial_rx,
    output logic        sel,
    output logic [31:0] rdata,
    output logic        serial_tx
);

    localparam int BIT_CYC = CLOCK_FREQ / BAUD_RATE;
    localparam int CW      = cnt_width(BIT_CYC);
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);

    logic [7:0] off;
    logic       is_store, is_load;
    logic       tx_start, cnt_clear, status_rd, rx_rd, rx_pop;
    logic       tx_ready, rx_valid, rx_drop;
    logic [7:0] rx_head;
    logic [7:0] rx_data;
    logic       rx_strobe;
    logic       overrun_reg;
    logic [31:0] cyc_cnt_reg, inst_cnt_reg;

    logic unused_bits;
    assign unused_bits = ^{wdata[31:8], addr[27:8]};

    // Decode: side effects only for accesses that hit the MMIO window
    assign off       = addr[7:0];
    assign sel       = (addr[31:28] == MMIO_NIB);
    assign is_store  = sel && (we != 4'b0);
    assign is_load   = sel && re;
    assign tx_start  = is_store && (off == UART_TX) && tx_ready;
    assign cnt_clear = is_store && (off == CNT_RST);
    assign status_rd = is_load && (off == UART_CTRL);
    assign rx_rd     = is_load && (off == UART_RX);
    assign rx_pop    = rx_rd && rx_valid;

    // ------------------------------------------------------------------
    // Transmitter: shift register idles all-ones, so its LSB is the line
    // ------------------------------------------------------------------
    tx_state_t      tx_state_reg, tx_state_next;
    logic [9:0]     tx_shift_reg, tx_shift_next;
    logic [3:0]     tx_bit_reg, tx_bit_next;
    logic [CW-1:0]  tx_cnt_reg, tx_cnt_next;

    // Transmitter state and frame registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_reg <= TX_IDLE;
            tx_shift_reg <= '1;
            tx_bit_reg   <= '0;
            tx_cnt_reg   <= '0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_shift_reg <= tx_shift_next;
            tx_bit_reg   <= tx_bit_next;
            tx_cnt_reg   <= tx_cnt_next;
        end
    end

    // Load a frame on an accepted store, then shift one bit every BIT_CYC
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_shift_next = tx_shift_reg;
        tx_bit_next   = tx_bit_reg;
        tx_cnt_next   = tx_cnt_reg;
        case (tx_state_reg)
            TX_IDLE: begin
                if (tx_start) begin
                    tx_state_next = TX_SHIFT;
                    tx_shift_next = {1'b1, wdata[7:0], 1'b0};
                    tx_bit_next   = '0;
                    tx_cnt_next   = '0;
                end
            end
            TX_SHIFT: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_shift_next = {1'b1, tx_shift_reg[9:1]};
                    if (tx_bit_reg == 4'd9) begin
                        tx_state_next = TX_IDLE;
                    end else begin
                        tx_bit_next = tx_bit_reg + 1'b1;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg + 1'b1;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    assign tx_ready  = (tx_state_reg == TX_IDLE);
    assign serial_tx = tx_shift_reg[0];

    // ------------------------------------------------------------------
    // Receiver and receive buffering
    // ------------------------------------------------------------------
    uart_rx #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .serial_rx (serial_rx),
        .rx_data   (rx_data),
        .rx_strobe (rx_strobe)
    );

`ifdef UART_RX_FIFO_EN
    localparam int PW = $clog2(RX_FIFO_DEPTH);

    logic [7:0]    fifo_mem [RX_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [PW:0]   count_reg;
    logic          fifo_full, push;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept
    assign fifo_full = (count_reg == (PW+1)'(RX_FIFO_DEPTH));
    assign push      = rx_strobe && (!fifo_full || rx_pop);
    assign rx_drop   = rx_strobe && fifo_full && !rx_pop;
    assign rx_valid  = (count_reg != '0);
    assign rx_head   = fifo_mem[rd_ptr_reg];

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= rx_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rx_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !rx_pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!push && rx_pop) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end
`else
    logic [7:0] rx_byte_reg;
    logic       rx_valid_reg;

    assign rx_drop  = rx_strobe && rx_valid_reg && !rx_pop;
    assign rx_valid = rx_valid_reg;
    assign rx_head  = rx_byte_reg;

    // Single-byte holding register; an unread byte is never overwritten
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_byte_reg  <= '0;
            rx_valid_reg <= 1'b0;
        end else if (rx_strobe) begin
            if (!rx_valid_reg || rx_pop) begin
                rx_byte_reg  <= rx_data;
                rx_valid_reg <= 1'b1;
            end
        end else if (rx_pop) begin
            rx_valid_reg <= 1'b0;
        end
    end
`endif

    // Overrun is sticky until status is read; a new drop wins over the clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun_reg <= 1'b0;
        end else if (rx_drop) begin
            overrun_reg <= 1'b1;
        end else if (status_rd) begin
            overrun_reg <= 1'b0;
        end
    end

    // Performance counters; a clear overrides a same-cycle increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt_reg  <= '0;
            inst_cnt_reg <= '0;
        end else if (cnt_clear) begin
            cyc_cnt_reg  <= '0;
            inst_cnt_reg <= '0;
        end else begin
            cyc_cnt_reg  <= cyc_cnt_reg + 32'd1;
            inst_cnt_reg <= inst_cnt_reg + {31'b0, inst_retire};
        end
    end

    // Same-cycle read data for the writeback mux
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (off)
                UART_CTRL: rdata = {29'b0, overrun_reg, rx_valid, tx_ready};
                UART_RX:   rdata = rx_valid ? {24'b0, rx_head} : 32'b0;
                CYC_CNT:   rdata = cyc_cnt_reg;
                INST_CNT:  rdata = inst_cnt_reg;
                default:   rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Self-checking bench for uart_mmio: register-decode vector table, TX frame
// scoreboard, RX byte scoreboard with a small buffer model, counter and
// reset-mid-frame sequences.
module tb_uart_mmio;

`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 8;
`else
    localparam int DEPTH = 1;
`endif

    localparam logic [31:0] A_STAT = 32'h8000_0000;
    localparam logic [31:0] A_RX   = 32'h8000_0004;
    localparam logic [31:0] A_TX   = 32'h8000_0008;
    localparam logic [31:0] A_CYC  = 32'h8000_0010;
    localparam logic [31:0] A_INST = 32'h8000_0014;
    localparam logic [31:0] A_CRST = 32'h8000_0018;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  we = '0;
    logic        re = 1'b0;
    logic        inst_retire = 1'b0;
    logic        serial_rx = 1'b1;
    logic        sel;
    logic [31:0] rdata;
    logic        serial_tx;

    int tests = 0;
    int fails = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int         model_count = 0;
    logic       model_overrun = 1'b0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic        re;
        logic        exp_sel;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[12];

    uart_mmio #(
        .CLOCK_FREQ (1_000_000),
        .BAUD_RATE  (100_000),
        .MMIO_NIB   (4'h8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .wdata       (wdata),
        .we          (we),
        .re          (re),
        .inst_retire (inst_retire),
        .serial_rx   (serial_rx),
        .sel         (sel),
        .rdata       (rdata),
        .serial_tx   (serial_tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", name, act);
        end
    endtask

    function automatic logic [31:0] exp_status();
        return {29'b0, model_overrun, (model_count > 0), 1'b1};
    endfunction

    // All bus tasks start and end on a falling edge
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 4'hF;
        @(negedge clk);
        we = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; re = 1'b1;
        #2 d = rdata;
        @(negedge clk);
        re = 1'b0;
    endtask

    task automatic check_status(input string name);
        logic [31:0] d;
        bus_read(A_STAT, d);
        check(name, d, exp_status());
        model_overrun = 1'b0;
    endtask

    task automatic check_pop(input string name);
        logic [31:0] d;
        logic [31:0] exp;
        bus_read(A_RX, d);
        if (model_count > 0) begin
            exp = {24'b0, rx_q.pop_front()};
            model_count--;
        end else begin
            exp = 32'b0;
        end
        check(name, d, exp);
    endtask

    // Drive one 8N1 frame; the model decides acceptance at drive time
    task automatic send_rx(input logic [7:0] b, input logic stop);
        serial_rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_rx = b[i];
            repeat (10) @(negedge clk);
        end
        serial_rx = stop;
        repeat (10) @(negedge clk);
        serial_rx = 1'b1;
        repeat (4) @(negedge clk);
        if (stop) begin
            if (model_count < DEPTH) begin
                rx_q.push_back(b);
                model_count++;
            end else begin
                model_overrun = 1'b1;
            end
        end
    endtask

    // Check the frame at the queue head cycle-by-cycle; entered at frame cycle start_k
    task automatic tx_expect(input int start_k, input string name);
        logic [7:0] b;
        logic [9:0] frame;
        logic [9:0] act;
        b = tx_q.pop_front();
        frame = {1'b1, b, 1'b0};
        act = frame;
        addr = A_STAT;
        #1;
        check({name, "_busy"}, {31'b0, rdata[0]}, 32'd0);
        for (int k = start_k; k < 100; k++) begin
            if (serial_tx !== frame[k/10]) act[k/10] = serial_tx;
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            check($sformatf("%s_bit%0d", name, i), {31'b0, act[i]}, {31'b0, frame[i]});
        end
        check({name, "_ready_after_stop"}, {31'b0, rdata[0]}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        tests++;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        logic [31:0] d;
        logic        idle_act;

        vecs[0]  = '{A_STAT,        4'h0, 32'h0,  1'b1, 1'b1, 32'h1};
        vecs[1]  = '{A_RX,          4'h0, 32'h0,  1'b1, 1'b1, 32'h0};
        vecs[2]  = '{A_TX,          4'h0, 32'h0,  1'b1, 1'b1, 32'h0};
        vecs[3]  = '{32'h8000_000C, 4'h0, 32'h0,  1'b1, 1'b1, 32'h0};
        vecs[4]  = '{A_INST,        4'h0, 32'h0,  1'b1, 1'b1, 32'h0};
        vecs[5]  = '{A_CRST,        4'h0, 32'h0,  1'b1, 1'b1, 32'h0};
        vecs[6]  = '{32'h9000_0000, 4'h0, 32'h0,  1'b1, 1'b0, 32'h0};
        vecs[7]  = '{32'h0000_0010, 4'h0, 32'h0,  1'b1, 1'b0, 32'h0};
        vecs[8]  = '{32'h8000_001C, 4'hF, 32'hFF, 1'b0, 1'b1, 32'h0};
        vecs[9]  = '{32'h7000_0008, 4'hF, 32'h41, 1'b0, 1'b0, 32'h0};
        vecs[10] = '{A_STAT,        4'h0, 32'h0,  1'b1, 1'b1, 32'h1};
        vecs[11] = '{32'h8000_0100, 4'h0, 32'h0,  1'b1, 1'b1, 32'h1};

        repeat (3) @(negedge clk);
        #1 check("reset_serial_tx", {31'b0, serial_tx}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Register decode table
        for (int i = 0; i < 12; i++) begin
            addr = vecs[i].addr; we = vecs[i].we; wdata = vecs[i].wdata; re = vecs[i].re;
            #2;
            check($sformatf("vec%0d_sel", i), {31'b0, sel}, {31'b0, vecs[i].exp_sel});
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            @(negedge clk);
        end
        we = 4'h0; re = 1'b0;

        // TX: plain frame
        bus_write(A_TX, 32'h0000_0055);
        tx_q.push_back(8'h55);
        tx_expect(0, "tx55");

        // TX: second store while busy is dropped
        bus_write(A_TX, 32'h0000_00A5);
        tx_q.push_back(8'hA5);
        bus_write(A_TX, 32'h0000_000F);
        tx_expect(1, "txA5");
        idle_act = 1'b1;
        repeat (20) begin
            if (serial_tx !== 1'b1) idle_act = serial_tx;
            @(negedge clk);
        end
        check("tx_busy_store_dropped", {31'b0, idle_act}, 32'd1);

        // RX: single byte
        send_rx(8'hA3, 1'b1);
        check_status("rx_status_full");
        check_pop("rx_popA3");
        check_status("rx_status_empty");

        // RX: two bytes without popping
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        check_status("rx2_status");
        check_pop("rx2_pop1");
        check_pop("rx2_pop2");
        check_status("rx2_status_end");

        // RX: one more byte than the buffer holds
        for (int i = 0; i <= DEPTH; i++) send_rx(8'h40 + 8'(i), 1'b1);
        check_status("fill_status");
        for (int i = 0; i <= DEPTH; i++) check_pop($sformatf("fill_pop%0d", i));
        check_status("fill_status_end");

        // RX: false start
        serial_rx = 1'b0;
        repeat (3) @(negedge clk);
        serial_rx = 1'b1;
        repeat (30) @(negedge clk);
        check_status("false_start_status");
        send_rx(8'h5A, 1'b1);
        check_pop("after_false_start_pop");

        // RX: framing error
        send_rx(8'h7E, 1'b0);
        repeat (10) @(negedge clk);
        check_status("framing_status");
        check_pop("framing_pop_empty");

        // Counters
        bus_write(A_CRST, 32'h0);
        for (int i = 0; i < 100; i++) begin
            inst_retire = (i < 37);
            @(negedge clk);
        end
        inst_retire = 1'b0;
        bus_read(A_CYC, d);
        check("cyc_cnt_100", d, 32'd100);
        bus_read(A_INST, d);
        check("inst_cnt_37", d, 32'd37);
        inst_retire = 1'b1;
        bus_write(A_CRST, 32'h1234);
        inst_retire = 1'b0;
        bus_read(A_CYC, d);
        check("cyc_cnt_cleared", d, 32'd0);
        bus_read(A_INST, d);
        check("inst_cnt_clear_wins", d, 32'd0);

        // Reset in the middle of a TX frame
        bus_write(A_TX, 32'h0000_003C);
        repeat (25) @(negedge clk);
        addr = A_STAT;
        #1 rst = 1'b0;
        #1;
        check("rst_mid_tx_line", {31'b0, serial_tx}, 32'd1);
        check("rst_mid_tx_status", rdata, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        tx_q.delete();
        rx_q.delete();
        model_count = 0;
        model_overrun = 1'b0;
        @(negedge clk);
        bus_write(A_TX, 32'h0000_003C);
        tx_q.push_back(8'h3C);
        tx_expect(0, "tx3C_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
